// File: rtl/counter_sram_pkg.sv
// Shared constants and FSM state encoding for the counter_sram block.
// The optional DONE_HOLD_EN build macro is consumed by counter_sram.sv.
`timescale 1ns/1ps
package counter_sram_pkg;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 1024;
  localparam int RES_W  = 20;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    READ = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/counter_sram_sram.sv
// Single-port 1024x8 SRAM: synchronous write, registered read, no reset on
// the storage or the read register so contents survive a block reset.
`timescale 1ns/1ps
module sram_sp
  import counter_sram_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] data [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      data[addr] <= wdata;
    end
    if (re) begin
      rdata <= data[addr];
    end
  end

endmodule

// File: rtl/counter_sram.sv
// Fills an on-chip SRAM with addr[7:0], reads it back and accumulates the sum.
// Build macro DONE_HOLD_EN: hold `done` high in DONE until the next start.
`timescale 1ns/1ps
module counter_sram
  import counter_sram_pkg::*;
(
  input  logic             rst,
  input  logic             clk,
  output logic [RES_W-1:0] result,
  input  logic             i_en,
  output logic             done
);

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic              rd_last;
  logic              vld_p1;
  logic [DATA_W-1:0] rdata_p1;
  logic              we;
  logic              re;

  function automatic logic [RES_W-1:0] acc_add(input logic [RES_W-1:0] acc,
                                                input logic [DATA_W-1:0] val);
    return acc + {{(RES_W - DATA_W){1'b0}}, val};
  endfunction

  assign we = (state == FILL);
  assign re = (state == READ) && !rd_last;

  // Stage p0 -> p1: address issued to the SRAM, read data registered inside it
  sram_sp u0 (
    .clk   (clk),
    .we    (we),
    .re    (re),
    .addr  (addr),
    .wdata (addr[DATA_W-1:0]),
    .rdata (rdata_p1)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      addr    <= '0;
      rd_last <= 1'b0;
      vld_p1  <= 1'b0;
      result  <= '0;
      done    <= 1'b0;
    end else begin
      vld_p1 <= 1'b0;
      // Stage p1: fold the registered read data into the running sum
      if (vld_p1) begin
        result <= acc_add(result, rdata_p1);
      end

      case (state)
        IDLE: begin
          if (i_en) begin
            state   <= FILL;
            addr    <= '0;
            rd_last <= 1'b0;
            result  <= '0;
          end
        end

        FILL: begin
          if (addr == LAST_ADDR) begin
            state <= READ;
            addr  <= '0;
          end else begin
            addr <= addr + 1'b1;
          end
        end

        READ: begin
          if (!rd_last) begin
            vld_p1 <= 1'b1;
            if (addr == LAST_ADDR) begin
              rd_last <= 1'b1;
              addr    <= '0;
            end else begin
              addr <= addr + 1'b1;
            end
          end else begin
            // Last read data was summed on this edge, so result is final here
            state <= DONE;
            done  <= 1'b1;
          end
        end

        DONE: begin
`ifdef DONE_HOLD_EN
          if (i_en) begin
            state   <= FILL;
            addr    <= '0;
            rd_last <= 1'b0;
            result  <= '0;
            done    <= 1'b0;
          end
`else
          state   <= IDLE;
          rd_last <= 1'b0;
          done    <= 1'b0;
`endif
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_counter_sram.sv
// Directed bench for counter_sram: full runs, memory contents, glitchy start,
// mid-run reset, start-in-DONE handling and (with DONE_HOLD_EN) held done.
`timescale 1ns/1ps
module tb_counter_sram;
  import counter_sram_pkg::*;

  logic             rst;
  logic             clk;
  logic [RES_W-1:0] result;
  logic             i_en;
  logic             done;

  int n_chk;
  int n_pass;
  int done_cnt;

  localparam int FULL_SUM = 130560;

  counter_sram dut (
    .rst    (rst),
    .clk    (clk),
    .result (result),
    .i_en   (i_en),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial done_cnt = 0;
  always @(negedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic edge_();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input string tag, input bit glitch);
    if (glitch) begin
      #3 i_en = 1'b1;
      #7 i_en = 1'b0;
    end else begin
      i_en = 1'b1;
      edge_();
      i_en = 1'b0;
    end
    chk({tag, "_clr"}, 32'(result), 0);
    chk({tag, "_fill"}, 32'(dut.state), 32'(FILL));
  endtask

  task automatic finish_run(input string tag, input int pulse_at);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 3000) begin
      if (n == pulse_at) i_en = 1'b1;
      edge_();
      i_en = 1'b0;
      n++;
      if (n == 1024) chk({tag, "_rd_st"}, 32'(dut.state), 32'(READ));
      if (n == 1026) chk({tag, "_acc0"}, 32'(result), 0);
      if (n == 1027) chk({tag, "_acc1"}, 32'(result), 1);
      if (n == 1280) chk({tag, "_acc254"}, 32'(result), 32385);
    end
    chk({tag, "_lat"}, 32'(n), 2049);
    chk({tag, "_res"}, 32'(result), FULL_SUM);
    chk({tag, "_done"}, 32'(done), 1);
  endtask

  task automatic idle_tail(input string tag);
    edge_();
    chk({tag, "_dn0"}, 32'(done), 0);
    chk({tag, "_idle"}, 32'(dut.state), 32'(IDLE));
    chk({tag, "_hold"}, 32'(result), FULL_SUM);
  endtask

  initial begin
    int base;
    int bad;
    n_chk  = 0;
    n_pass = 0;
    rst    = 1'b0;
    i_en   = 1'b0;

    // Reset values
    #12;
    chk("rst_res", 32'(result), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_state", 32'(dut.state), 32'(IDLE));
    rst = 1'b1;
    edge_();
    edge_();
    chk("idle_stay", 32'(dut.state), 32'(IDLE));

    // Basic full run
    base = done_cnt;
    start_run("run1", 1'b0);
    finish_run("run1", -1);
`ifndef DONE_HOLD_EN
    idle_tail("run1");
    chk("run1_pulses", 32'(done_cnt - base), 1);
`else
    bad = 0;
    repeat (100) begin
      edge_();
      if (done !== 1'b1 || result !== RES_W'(FULL_SUM)) bad++;
    end
    chk("hold_100", 32'(bad), 0);
    chk("hold_state", 32'(dut.state), 32'(DONE));
    i_en = 1'b1;
    edge_();
    i_en = 1'b0;
    chk("hold_drop", 32'(done), 0);
    chk("hold_clr", 32'(result), 0);
    chk("hold_fill", 32'(dut.state), 32'(FILL));
    finish_run("hold_run", -1);
`endif

    // Memory contents after a run
    bad = 0;
    for (int k = 0; k < DEPTH; k++) begin
      if (dut.u0.data[k] !== 8'(k)) bad++;
    end
    chk("mem_all", 32'(bad), 0);
    chk("mem_300", 32'(dut.u0.data[300]), 32'h2C);
    chk("mem_1023", 32'(dut.u0.data[1023]), 32'hFF);

    // 7 ns start pulse plus a second pulse during FILL
    base = done_cnt;
    start_run("glitch", 1'b1);
    finish_run("glitch", 10);
`ifndef DONE_HOLD_EN
    // Start in DONE is ignored, start in the following IDLE begins a new run
    i_en = 1'b1;
    edge_();
    chk("indone_dn0", 32'(done), 0);
    chk("indone_idle", 32'(dut.state), 32'(IDLE));
    chk("indone_res", 32'(result), FULL_SUM);
    chk("glitch_pulses", 32'(done_cnt - base), 1);
    edge_();
    i_en = 1'b0;
    chk("b2b_clr", 32'(result), 0);
    chk("b2b_fill", 32'(dut.state), 32'(FILL));
    finish_run("b2b", -1);
    idle_tail("b2b");
`endif

    // Reset at E500 aborts the run without clearing the SRAM
    start_run("abort", 1'b0);
    repeat (499) edge_();
    chk("abort_addr_pre", 32'(dut.addr), 499);
    rst = 1'b0;
    #1;
    chk("abort_res", 32'(result), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_state", 32'(dut.state), 32'(IDLE));
    chk("abort_addr", 32'(dut.addr), 0);
    #2 rst = 1'b1;
    edge_();
    chk("abort_idle", 32'(dut.state), 32'(IDLE));
    chk("abort_mem700", 32'(dut.u0.data[700]), 188);
    start_run("rerun", 1'b0);
    finish_run("rerun", -1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/counter_sram.md
COUNTER_SRAM -- requirements
Module: counter_sram

Interface
REQ-001 The block SHALL expose these ports: `clk` input, 1 bit, rising-edge clock.
REQ-002 The block SHALL expose `rst` input, 1 bit, reset; one clock; reset is asynchronous and active-low.
REQ-003 The block SHALL expose `result` output, 20 bits, the running/final accumulated sum of SRAM contents.
REQ-004 The block SHALL expose `i_en` input, 1 bit, start request, level-sampled on `clk`.
REQ-005 The block SHALL expose `done` output, 1 bit, completion flag.
REQ-006 Port order SHALL be `rst`, `clk`, `result`, `i_en`, `done`.

Function
REQ-007 The FSM SHALL have states IDLE, FILL, READ and DONE; after reset it SHALL be in IDLE.
REQ-008 In IDLE, a rising edge with `i_en`=1 (start edge E0) SHALL enter FILL, set addr=0 and clear `result` to 0.
REQ-009 In IDLE, `i_en`=0 SHALL keep the FSM in IDLE; `i_en` in any other state SHALL be ignored.
REQ-010 In FILL, each edge SHALL write data[addr] = addr[7:0], then increment addr.
- Edges E1..E1024 cover addr 0..1023.
- At addr 1023 the FSM SHALL go to READ with addr=0.
REQ-011 The SRAM SHALL be single-port, 1024 x 8, with a synchronous write and a registered read (rdata valid one cycle after the address is issued).
REQ-012 In READ, each edge E1025..E2048 SHALL issue read addr 0..1023.
REQ-013 `result` SHALL add the zero-extended rdata one cycle after each read is issued (edges E1026..E2049), using 20-bit unsigned arithmetic with no overflow (maximum 261120).
REQ-014 At edge E2049 the FSM SHALL enter DONE and `done` SHALL go 1 together with the final `result`.
REQ-015 At E2050 the FSM SHALL return to IDLE with `done`=0 (one-cycle pulse by default).
REQ-016 `result` SHALL hold its final value in IDLE until the next start edge.
REQ-017 A start edge arriving in DONE SHALL be ignored; a start edge arriving in the following IDLE SHALL start a new run.

Reset
REQ-018 Asserting `rst` low SHALL immediately force: state=IDLE, addr=0, `result`=0, `done`=0.
REQ-019 Reset mid-run SHALL abort the run; SRAM contents SHALL NOT be cleared (there is no SRAM reset).
REQ-020 Reset deassertion SHALL take effect on the next rising `clk`.

Configuration
REQ-021 Macro DONE_HOLD_EN, when defined, SHALL keep `done` high and the FSM in DONE until the next start edge (`i_en`=1).
- That start edge SHALL clear `done` and `result` and enter FILL.
REQ-022 Without DONE_HOLD_EN, `done` SHALL be the one-cycle pulse of REQ-014/REQ-015.

Structure
REQ-023 Package `counter_sram_pkg` SHALL hold:
- constants ADDR_W=10, DATA_W=8, DEPTH=1024, RES_W=20;
- the FSM state enum.
REQ-024 The SRAM SHALL be a sub-module `sram_sp`, instanced as `u0`, with storage array named `data` (hierarchical path u0.data) so benches can dump it with a memory write task.
REQ-025 Counter, FSM and accumulator SHALL live in `counter_sram`.

Verification
REQ-026 Scenario: reset low, then high; `i_en` high for one edge -> `done` rises exactly 2049 edges later, `result`=20'h1FE00 (130560), `done` high for one cycle.
REQ-027 Scenario: after a run, dump u0.data -> data[k] = k mod 256 for k=0..1023 (e.g. data[300]=8'h2C).
REQ-028 Scenario: `i_en` held high for 7 ns, then pulsed again during FILL -> single run, `done` count = 1, `result`=130560.
REQ-029 Scenario: `rst` low at edge E500 -> `result`=0, `done`=0, state IDLE; a new start gives a correct full run (`result`=130560).
REQ-030 Scenario: two back-to-back runs -> `result` cleared to 0 at the second start, final value 130560 again.
REQ-031 Scenario (DONE_HOLD_EN): `done` stays 1 for 100 cycles with `i_en`=0; an `i_en` pulse drops `done` on that edge.
